// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, default widths, result-stage occupancy encoding.
// Used by the ALU, the decoder and alu_result_stage.
package alu_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int ENTRY_W     = XLEN_DEF + 1 + RADDR_W_DEF;

  localparam logic [5:0] ALU_ADD  = 6'h00;
  localparam logic [5:0] ALU_SUB  = 6'h01;
  localparam logic [5:0] ALU_AND  = 6'h02;
  localparam logic [5:0] ALU_OR   = 6'h03;
  localparam logic [5:0] ALU_XOR  = 6'h04;
  localparam logic [5:0] ALU_SLL  = 6'h05;
  localparam logic [5:0] ALU_SRL  = 6'h06;
  localparam logic [5:0] ALU_SRA  = 6'h07;
  localparam logic [5:0] ALU_SLT  = 6'h08;
  localparam logic [5:0] ALU_SLTU = 6'h09;
  localparam logic [5:0] ALU_BEQ  = 6'h10;
  localparam logic [5:0] ALU_BNE  = 6'h11;
  localparam logic [5:0] ALU_BLT  = 6'h12;
  localparam logic [5:0] ALU_BGE  = 6'h13;
  localparam logic [5:0] ALU_BLTU = 6'h14;
  localparam logic [5:0] ALU_BGEU = 6'h15;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_stage_skid.sv
// Two-entry skid buffer, generic width. Head is the oldest entry; ready is registered
// from the next occupancy so it never depends combinationally on pop.
module alu_stage_skid
  import alu_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         ready_o,
  output logic         head_valid_o,
  output logic         skid_valid_o,
  output logic [W-1:0] head_o,
  output logic [W-1:0] skid_o
);

  occ_e         state_q, state_d;
  logic         ready_q;
  logic [W-1:0] head_q, skid_q, head_nx;
  logic         head_ld, skid_ld;

  always_comb begin
    state_d = state_q;
    head_ld = 1'b0;
    skid_ld = 1'b0;
    head_nx = din_i;
    if (flush_i) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (push_i) begin
            state_d = OCC_ONE;
            head_ld = 1'b1;
          end
        end
        OCC_ONE: begin
          if (push_i && pop_i) begin
            head_ld = 1'b1;
          end else if (push_i) begin
            state_d = OCC_TWO;
            skid_ld = 1'b1;
          end else if (pop_i) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // push cannot occur here: ready was low for this cycle
          if (pop_i) begin
            state_d = OCC_ONE;
            head_ld = 1'b1;
            head_nx = skid_q;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OCC_EMPTY;
      ready_q <= 1'b1;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != OCC_TWO);
      if (head_ld) head_q <= head_nx;
      if (skid_ld) skid_q <= din_i;
    end
  end

  assign ready_o      = ready_q;
  assign head_valid_o = (state_q != OCC_EMPTY);
  assign skid_valid_o = (state_q == OCC_TWO);
  assign head_o       = head_q;
  assign skid_o       = skid_q;

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: skid-buffers ALU results toward the register file and
// resolves conditional branches into a one-cycle redirect. Optional bypass: ALU_STAGE_FWD_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic               alu_cmp_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               wb_en_i,
  input  logic               branch_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    imm_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic               wb_we_o,
  output logic [RADDR_W-1:0] wb_addr_o,
  output logic [XLEN-1:0]    wb_data_o,
  output logic               redirect_o,
  output logic [XLEN-1:0]    redirect_pc_o
`ifdef ALU_STAGE_FWD_EN
  ,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_addr_o,
  output logic [XLEN-1:0]    fwd_data_o
`endif
);

  localparam int EW = XLEN + 1 + RADDR_W;

  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic               we;
    logic [RADDR_W-1:0] addr;
  } entry_t;

  entry_t         in_ent, head, skid;
  logic           head_valid, skid_valid, accept, pop, taken;
  logic           redir_q;
  logic [XLEN-1:0] rpc_q;

  // flush wins: an entry offered in the flush cycle is neither stored nor resolved
  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign pop    = head_valid && wb_ready_i;
  assign taken  = accept && branch_i && alu_cmp_i;

  always_comb begin
    in_ent      = '0;
    in_ent.data = alu_result_i;
    in_ent.we   = wb_en_i && !branch_i && (rd_addr_i != '0);
    in_ent.addr = rd_addr_i;
  end

  alu_stage_skid #(.W(EW)) u_skid (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_i       (accept),
    .pop_i        (pop),
    .din_i        (in_ent),
    .ready_o      (in_ready_o),
    .head_valid_o (head_valid),
    .skid_valid_o (skid_valid),
    .head_o       (head),
    .skid_o       (skid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      redir_q <= taken;
      if (taken) rpc_q <= pc_i + imm_i;
    end
  end

  assign wb_valid_o    = head_valid;
  assign wb_we_o       = head.we;
  assign wb_addr_o     = head.addr;
  assign wb_data_o     = head.data;
  assign redirect_o    = redir_q;
  assign redirect_pc_o = rpc_q;

`ifdef ALU_STAGE_FWD_EN
  always_comb begin
    fwd_valid_o = 1'b0;
    fwd_addr_o  = '0;
    fwd_data_o  = '0;
    if (skid_valid && skid.we) begin
      fwd_valid_o = 1'b1;
      fwd_addr_o  = skid.addr;
      fwd_data_o  = skid.data;
    end else if (head_valid && head.we) begin
      fwd_valid_o = 1'b1;
      fwd_addr_o  = head.addr;
      fwd_data_o  = head.data;
    end
  end
`else
  logic unused_skid;
  assign unused_skid = ^{skid, skid_valid};
`endif

endmodule
